vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 93 +++++++++
 tb/tb_vga_timing_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel enable and match line in, counters, syncs and strobes out.
interface vga_timing_if #(
  parameter int unsigned CW = 11
);
  logic          ce;
  logic [CW-1:0] match_line;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          newline;
  logic          newframe;
  logic          line_match;

  // Timing generator side
  modport master (
    input  ce, match_line,
    output h_count, v_count, hsync, vsync, de, newline, newframe, line_match
  );

  // Renderer side
  modport slave (
    output ce, match_line,
    input  h_count, v_count, hsync, vsync, de, newline, newframe, line_match
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: one free-running h/v counter pair with
// all sync, enable and strobe outputs decoded from the next counter values.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FRONT  = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BACK   = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FRONT  = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BACK   = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CW       = 11
) (
  input  logic          clk50,
  input  logic          rst_n,
  vga_timing_if.master  vif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  // Reject geometries the counters cannot represent or with empty regions
  if (64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2^CW");
  end
  if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be at least 1");
  end

  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          de_nxt;
  logic          match_nxt;

  // Next counter position and its region decode
  always_comb begin
    h_wrap    = (vif.h_count == H_LAST);
    v_wrap    = (vif.v_count == V_LAST);
    h_nxt     = h_wrap ? '0 : vif.h_count + CW'(1);
    v_nxt     = vif.v_count;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vif.v_count + CW'(1);
    end
    hs_nxt    = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
    vs_nxt    = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
    de_nxt    = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
    match_nxt = h_wrap && (v_nxt == vif.match_line);
  end

  // Counters and registered outputs; advance on ce, strobes live for one clock
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      vif.h_count    <= H_LAST;
      vif.v_count    <= V_LAST;
      vif.hsync      <= ~HS_POL;
      vif.vsync      <= ~VS_POL;
      vif.de         <= 1'b0;
      vif.newline    <= 1'b0;
      vif.newframe   <= 1'b0;
      vif.line_match <= 1'b0;
    end else if (vif.ce) begin
      vif.h_count    <= h_nxt;
      vif.v_count    <= v_nxt;
      vif.hsync      <= hs_nxt;
      vif.vsync      <= vs_nxt;
      vif.de         <= de_nxt;
      vif.newline    <= h_wrap;
      vif.newframe   <= h_wrap && v_wrap;
      vif.line_match <= match_nxt;
    end else begin
      vif.newline    <= 1'b0;
      vif.newframe   <= 1'b0;
      vif.line_match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two geometries driven by shared ce/match_line,
// every output compared each clock against a position-arithmetic model.
module tb_vga_timing_gen;

  logic        clk50;
  logic        rst_n;
  logic        ce;
  logic [10:0] ml;

  int          checks;
  int          errors;
  longint      k;        // ce edges since last reset release
  bit          ce_edge;  // last clock edge advanced the raster
  int          ml_s;     // match_line seen at that edge

  vga_timing_if #(.CW(11)) ifa ();
  vga_timing_if #(.CW(11)) ifb ();

  assign ifa.ce         = ce;
  assign ifb.ce         = ce;
  assign ifa.match_line = ml;
  assign ifb.match_line = ml;

  // Small geometry, active-low syncs
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(11)
  ) dut_a (
    .clk50 (clk50),
    .rst_n (rst_n),
    .vif   (ifa)
  );

  // Default line timing, short frame, active-high syncs
  vga_timing_gen #(
    .H_ACTIVE(800), .H_FRONT(56), .H_SYNC(120), .H_BACK(64),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) dut_b (
    .clk50 (clk50),
    .rst_n (rst_n),
    .vif   (ifb)
  );

  initial begin
    clk50 = 1'b0;
    forever #5 clk50 = ~clk50;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs from the linear raster position reached after k ce edges
  task automatic check_one(input string name,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb,
                           input bit hp, input bit vp,
                           input logic [10:0] o_h, input logic [10:0] o_v,
                           input logic o_hs, input logic o_vs, input logic o_de,
                           input logic o_nl, input logic o_nf, input logic o_lm);
    longint ht, vt, f, p;
    int     h, v;
    bit     e_hs, e_vs, e_de, e_nl, e_nf, e_lm;
    ht   = longint'(ha + hf + hs + hb);
    vt   = longint'(va + vf + vs + vb);
    f    = ht * vt;
    p    = (f - 1 + k) % f;
    h    = int'(p % ht);
    v    = int'(p / ht);
    e_hs = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
    e_vs = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
    e_de = (h < ha) && (v < va);
    e_nl = ce_edge && (h == 0);
    e_nf = ce_edge && (p == 0);
    e_lm = e_nl && (v == ml_s);
    chk({name, ".h_count"},    32'(o_h),  32'(h));
    chk({name, ".v_count"},    32'(o_v),  32'(v));
    chk({name, ".hsync"},      32'(o_hs), 32'(e_hs));
    chk({name, ".vsync"},      32'(o_vs), 32'(e_vs));
    chk({name, ".de"},         32'(o_de), 32'(e_de));
    chk({name, ".newline"},    32'(o_nl), 32'(e_nl));
    chk({name, ".newframe"},   32'(o_nf), 32'(e_nf));
    chk({name, ".line_match"}, 32'(o_lm), 32'(e_lm));
  endtask

  task automatic check_both();
    check_one("a", 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0,
              ifa.h_count, ifa.v_count, ifa.hsync, ifa.vsync, ifa.de,
              ifa.newline, ifa.newframe, ifa.line_match);
    check_one("b", 800, 56, 120, 64, 4, 1, 2, 1, 1'b1, 1'b1,
              ifb.h_count, ifb.v_count, ifb.hsync, ifb.vsync, ifb.de,
              ifb.newline, ifb.newframe, ifb.line_match);
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge
  task automatic step(input bit c, input logic [10:0] m);
    ce = c;
    ml = m;
    @(posedge clk50);
    if (rst_n) begin
      k       += longint'(c);
      ce_edge  = c;
      ml_s     = int'(m);
    end else begin
      ce_edge  = 1'b0;
    end
    @(negedge clk50);
    check_both();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    k       = 0;
    ce_edge = 1'b0;
    ml_s    = 0;
    rst_n   = 1'b0;
    ce      = 1'b1;
    ml      = 11'd5;

    // Reset held: outputs at reset values while clocks run with ce high
    repeat (3) @(negedge clk50);
    check_both();
    step(1'b1, 11'd5);

    // Release; first ce lands on (0,0) with both strobes
    rst_n = 1'b1;
    for (int i = 0; i < 2 * 8320 + 200; i++) begin
      step(1'b1, 11'd5);
      if (errors > 200) break;
    end

    // ce every second clock, match line out of range
    for (int i = 0; i < 4000; i++) begin
      step(i[0], 11'd700);
      if (errors > 200) break;
    end

    // Random ce density and random match line (some beyond the frame)
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 3) != 0, 11'($urandom_range(0, 9)));
      if (errors > 200) break;
    end

    // Asynchronous reset mid-line: outputs jump immediately
    #2 rst_n = 1'b0;
    k       = 0;
    ce_edge = 1'b0;
    #1 check_both();
    @(posedge clk50);
    @(negedge clk50);
    check_both();
    rst_n = 1'b1;
    step(1'b0, 11'd0);
    step(1'b0, 11'd0);
    step(1'b1, 11'd0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) != 0, 11'($urandom_range(0, 8)));
      if (errors > 200) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
